// File: rtl/atm_pkg.sv
// Shared display constants for the ATM controller and the 7-segment scanner.
// Segment codes are abcdefg, with bit6 = a and 0 = segment lit.
package atm_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Hex digit fonts plus a dash, shared so both blocks agree on the codes
    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b1100000;
    localparam logic [6:0] SEG_C    = 7'b0110001;
    localparam logic [6:0] SEG_D    = 7'b1000010;
    localparam logic [6:0] SEG_E    = 7'b0110000;
    localparam logic [6:0] SEG_F    = 7'b0111000;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    // Active-low one-hot anode pattern for a slot (slot 3 = leftmost digit)
    function automatic logic [3:0] an_select(input logic [1:0] slot);
        an_select = ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/atm_slot_timer.sv
// Slot timer for the display scanner: counts REFRESH_DIV cycles per digit
// slot, steps the slot 3 -> 2 -> 1 -> 0 -> 3, decodes the blank/drive phase
// and flags the first cycle of each frame.
module atm_slot_timer
    import atm_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] o_slot,
    output phase_t     o_phase,
    output logic       o_frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_slot;

    // Cycle counter within the slot; the wrap advances to the next digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= 2'd3;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_slot <= r_slot - 2'd1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_slot  = r_slot;
    assign o_phase = (r_cnt < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    // Kept low during reset so nothing downstream sees a spurious frame start
    assign o_frame_tick = ~rst && (r_slot == 2'd3) && (r_cnt == '0);

endmodule

// File: rtl/atm_disp_scan.sv
// Time-multiplexed scanner for the BASYS2 4-digit 7-segment display.
// Snapshots all four digit codes once per frame, then drives one digit per
// slot with a leading blank gap to suppress ghosting.
// Optional whole-display blink: define ATM_DISP_BLINK_EN.
module atm_disp_scan
    import atm_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] digit4,
    input  logic [6:0] digit3,
    input  logic [6:0] digit2,
    input  logic [6:0] digit1,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);

    logic [1:0]      w_slot;
    phase_t          w_phase;
    logic            w_frame_tick;
    logic            w_dark;
    logic [3:0][6:0] r_snap;
    logic [6:0]      r_seg;
    logic [3:0]      r_an;

    atm_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .o_slot       (w_slot),
        .o_phase      (w_phase),
        .o_frame_tick (w_frame_tick)
    );

    // Capture all four codes together so a frame never mixes old and new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= {4{SEG_BLANK}};
        end else if (w_frame_tick) begin
            r_snap <= {digit4, digit3, digit2, digit1};
        end
    end

`ifdef ATM_DISP_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_HALF = FW'(BLINK_FRAMES / 2);

    logic [FW-1:0] r_frame_cnt;

    // Frame counter for the blink period; restarts whenever blink drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (!blink) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + FW'(1);
        end
    end

    // Second half of each blink period keeps the anodes off
    assign w_dark = blink && (r_frame_cnt >= FRAME_HALF);
`else
    // Blink is not built in: absorb the input and period parameter
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic w_unused_blink;
    assign w_unused_blink = blink;
    assign w_dark         = 1'b0;
`endif

    // Registered anode/cathode drive from the pre-edge slot, phase and snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else if (w_phase == PH_BLANK || w_dark) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= an_select(w_slot);
            r_seg <= r_snap[w_slot];
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign frame_tick = w_frame_tick;

endmodule
